// File: rtl/logicnets_layer_sched_pkg.sv
// Shared types and defaults for the serial LogicNets layer scheduler.
// Holds the FSM state encoding and the power-on connectivity mapping.
package logicnets_layer_sched_pkg;

  localparam int DEF_IN_BITS = 16;
  localparam int DEF_NEURONS = 16;
  localparam int DEF_FANIN   = 6;

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_eval  = 2'd1,
    st_drain = 2'd2,
    st_hold  = 2'd3
  } state_t;

  // Neurons tile the input vector in consecutive, wrapping windows of FANIN bits.
  function automatic int default_idx(input int n, input int s, input int fanin, input int in_bits);
    return (n * fanin + s) % in_bits;
  endfunction

endpackage

// File: rtl/logicnets_fanin_gather.sv
// Connectivity table (NEURONS x FANIN input indices) and the FANIN-way bit gather
// that forms the shared-LUT address for the neuron currently selected.
module logicnets_fanin_gather
  import logicnets_layer_sched_pkg::*;
#(
  parameter int IN_BITS = DEF_IN_BITS,
  parameter int NEURONS = DEF_NEURONS,
  parameter int FANIN   = DEF_FANIN,
  localparam int IW = $clog2(IN_BITS),
  localparam int NW = $clog2(NEURONS),
  localparam int SW = $clog2(FANIN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [NW-1:0]      cfg_neuron,
  input  logic [SW-1:0]      cfg_slot,
  input  logic [IW-1:0]      cfg_idx,
  input  logic [IN_BITS-1:0] x,
  input  logic [NW-1:0]      sel,
  output logic [FANIN-1:0]   lut_in
);

  logic [IW-1:0] idx [NEURONS][FANIN];
  logic          cfg_ok;

  // Out-of-range addresses are dropped rather than aliased onto a real entry.
  assign cfg_ok = cfg_we && (32'(cfg_neuron) < NEURONS) && (32'(cfg_slot) < FANIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NEURONS; n++)
        for (int s = 0; s < FANIN; s++)
          idx[n][s] <= IW'(default_idx(n, s, FANIN, IN_BITS));
    end else if (cfg_ok) begin
      idx[cfg_neuron][cfg_slot] <= cfg_idx;
    end
  end

  always_comb begin
    lut_in = '0;
    for (int s = 0; s < FANIN; s++)
      lut_in[s] = x[idx[sel][s]];
  end

endmodule

// File: rtl/logicnets_layer_sched.sv
// Evaluates one LogicNets layer by time-multiplexing all neurons onto a single
// external LUT with a one-cycle lookup latency.
//
// state    | meaning
// st_idle  | waiting for an input vector; table writes allowed
// st_eval  | one LUT lookup per cycle, neuron 0..NEURONS-1
// st_drain | collecting the last lookup result
// st_hold  | result presented until consumed
module logicnets_layer_sched
  import logicnets_layer_sched_pkg::*;
#(
  parameter int IN_BITS = DEF_IN_BITS,
  parameter int NEURONS = DEF_NEURONS,
  parameter int FANIN   = DEF_FANIN,
  localparam int IW = $clog2(IN_BITS),
  localparam int NW = $clog2(NEURONS),
  localparam int SW = $clog2(FANIN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_BITS-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NEURONS-1:0] out_data,
  output logic               lut_req,
  output logic [NW-1:0]      lut_sel,
  output logic [FANIN-1:0]   lut_in,
  input  logic               lut_out,
  input  logic               cfg_we,
  input  logic [NW-1:0]      cfg_neuron,
  input  logic [SW-1:0]      cfg_slot,
  input  logic [IW-1:0]      cfg_idx,
  output logic               busy
);

  state_t               state_q, state_d;
  logic [NW-1:0]        n_q;
  logic [IN_BITS-1:0]   x_q;
  logic [NEURONS-1:0]   result_q;
  logic                 req_d;
  logic [NW-1:0]        sel_d;
  logic                 accept;
  logic                 last;

  assign last = (n_q == NW'(NEURONS - 1));

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    lut_req   = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      st_idle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = st_eval;
        end
      end
      st_eval: begin
        lut_req = 1'b1;
        if (last) state_d = st_drain;
      end
      st_drain: state_d = st_hold;
      st_hold: begin
        out_valid = 1'b1;
        if (out_ready) state_d = st_idle;
      end
      default: state_d = st_idle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= st_idle;
      n_q      <= '0;
      x_q      <= '0;
      result_q <= '0;
      req_d    <= 1'b0;
      sel_d    <= '0;
    end else begin
      state_q <= state_d;
      req_d   <= lut_req;
      sel_d   <= n_q;
      if (accept) begin
        x_q      <= in_data;
        result_q <= '0;
        n_q      <= '0;
      end else if (lut_req) begin
        n_q <= last ? '0 : n_q + 1'b1;
      end
      // The LUT answers one cycle late, so the bit belongs to the previous selection.
      if (req_d) result_q[sel_d] <= lut_out;
    end
  end

  assign out_data = result_q;
  assign lut_sel  = n_q;
  assign busy     = (state_q != st_idle);

  // Table writes are accepted only while idle, including the acceptance cycle itself.
  logicnets_fanin_gather #(
    .IN_BITS(IN_BITS),
    .NEURONS(NEURONS),
    .FANIN  (FANIN)
  ) u_gather (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we && (state_q == st_idle)),
    .cfg_neuron(cfg_neuron),
    .cfg_slot  (cfg_slot),
    .cfg_idx   (cfg_idx),
    .x         (x_q),
    .sel       (lut_sel),
    .lut_in    (lut_in)
  );

endmodule

// File: tb/tb_logicnets_layer_sched.sv
// Bench for logicnets_layer_sched: XOR LUT with one-cycle latency, directed table
// vectors, random vectors against a table-level reference model, and corner sequences.
module tb_logicnets_layer_sched;

  localparam int IN_BITS = 16;
  localparam int NEURONS = 16;
  localparam int FANIN   = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        lut_req;
  logic [3:0]  lut_sel;
  logic [5:0]  lut_in;
  logic        lut_out = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_neuron = '0;
  logic [2:0]  cfg_slot = '0;
  logic [3:0]  cfg_idx = '0;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int req_cnt = 0;
  int tbl [NEURONS][FANIN];

  logicnets_layer_sched dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .lut_req(lut_req), .lut_sel(lut_sel), .lut_in(lut_in), .lut_out(lut_out),
    .cfg_we(cfg_we), .cfg_neuron(cfg_neuron), .cfg_slot(cfg_slot), .cfg_idx(cfg_idx),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // External LUT: parity of its address, answered one cycle later; noise when idle.
  always @(posedge clk) lut_out <= lut_req ? ^lut_in : 1'($urandom);
  always @(posedge clk) if (lut_req) req_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int n = 0; n < NEURONS; n++)
      for (int s = 0; s < FANIN; s++)
        tbl[n][s] = (n * FANIN + s) % IN_BITS;
  endfunction

  function automatic logic [15:0] model_out(input logic [15:0] x);
    logic [15:0] r;
    r = '0;
    for (int n = 0; n < NEURONS; n++) begin
      int ones = 0;
      for (int s = 0; s < FANIN; s++) ones += int'(x[tbl[n][s]]);
      r[n] = (ones % 2) == 1;
    end
    return r;
  endfunction

  function automatic void model_write(input int n, input int s, input int i);
    if (n < NEURONS && s < FANIN) tbl[n][s] = i;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Table write issued while the scheduler is idle.
  task automatic cfg_write(input int n, input int s, input int i);
    cfg_we = 1'b1; cfg_neuron = 4'(n); cfg_slot = 3'(s); cfg_idx = 4'(i);
    @(negedge clk);
    cfg_we = 1'b0;
    model_write(n, s, i);
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the handshake.
  task automatic start_vec(input string nm, input logic [15:0] d, input bit co,
                           input int cn, input int cs, input int ci, input bit stall,
                           output int base);
    chk({nm, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    out_ready = !stall;
    if (co) begin
      cfg_we = 1'b1; cfg_neuron = 4'(cn); cfg_slot = 3'(cs); cfg_idx = 4'(ci);
      model_write(cn, cs, ci);
    end
    base = req_cnt;
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    in_data  = 16'($urandom);
  endtask

  // Waits for the result; lat counts cycles from the handshake cycle.
  task automatic finish_vec(input string nm, input logic [15:0] exp, input int stall,
                            input int lat0, input int base);
    int lat;
    lat = lat0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, ".latency"}, 32'(lat), 32'd18);
    chk({nm, ".out_data"}, 32'(out_data), 32'(exp));
    chk({nm, ".lookups"}, 32'(req_cnt - base), 32'(NEURONS));
    for (int k = 0; k < stall; k++) begin
      chk({nm, ".hold"}, {out_valid, in_ready, lut_req, busy, 12'h0, out_data},
          {1'b1, 1'b0, 1'b0, 1'b1, 12'h0, exp});
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({nm, ".idle_after"}, {30'h0, out_valid, in_ready}, 32'h1);
  endtask

  typedef struct {
    int          wmode;   // 0 none, 1 write before, 2 write with acceptance
    int          cn, cs, ci;
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  initial begin
    vec_t vecs [6];
    int   base;
    int   seen;
    logic [15:0] d;

    vecs[0] = '{0, 0, 0, 0,  16'h0001, 16'h2525};
    vecs[1] = '{0, 0, 0, 0,  16'h8000, 16'hA4A4};
    vecs[2] = '{1, 3, 0, 15, 16'h8000, 16'hA4AC};
    vecs[3] = '{2, 3, 0, 0,  16'h0001, 16'h252D};
    vecs[4] = '{1, 0, 7, 15, 16'h0001, 16'h252D};
    vecs[5] = '{1, 0, 0, 15, 16'h8000, 16'hA4A5};

    model_reset();
    #1;
    chk("reset.outputs", {27'h0, in_ready, out_valid, lut_req, busy, |out_data}, 32'h10);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.after_release", {28'h0, in_ready, out_valid, lut_req, busy}, 32'h8);

    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      if (vecs[i].wmode == 1) cfg_write(vecs[i].cn, vecs[i].cs, vecs[i].ci);
      start_vec(nm, vecs[i].din, vecs[i].wmode == 2, vecs[i].cn, vecs[i].cs, vecs[i].ci,
                1'b0, base);
      finish_vec(nm, vecs[i].exp, 0, 1, base);
    end

    for (int r = 0; r < 10; r++) begin
      int st;
      if ($urandom_range(1, 0) == 1)
        cfg_write($urandom_range(15, 0), $urandom_range(5, 0), $urandom_range(15, 0));
      d  = 16'($urandom);
      st = $urandom_range(3, 0);
      start_vec($sformatf("rnd%0d", r), d, 1'b0, 0, 0, 0, st != 0, base);
      finish_vec($sformatf("rnd%0d", r), model_out(d), st, 1, base);
    end

    do_reset();
    start_vec("stall", 16'h0001, 1'b0, 0, 0, 0, 1'b1, base);
    finish_vec("stall", 16'h2525, 5, 1, base);

    // Table write attempted mid-evaluation must be ignored.
    start_vec("eval_cfg", 16'h0001, 1'b0, 0, 0, 0, 1'b0, base);
    @(negedge clk);
    @(negedge clk);
    chk("eval_cfg.in_eval", 32'(lut_req), 32'd1);
    cfg_we = 1'b1; cfg_neuron = 4'd0; cfg_slot = 3'd0; cfg_idx = 4'd15;
    @(negedge clk);
    cfg_we = 1'b0;
    finish_vec("eval_cfg", 16'h2525, 0, 4, base);
    start_vec("eval_cfg2", 16'h0001, 1'b0, 0, 0, 0, 1'b0, base);
    finish_vec("eval_cfg2", 16'h2525, 0, 1, base);

    // Reset in the fifth evaluation cycle aborts the vector and restores the table.
    cfg_write(0, 0, 15);
    start_vec("rst_mid", 16'h0001, 1'b0, 0, 0, 0, 1'b0, base);
    repeat (4) @(negedge clk);
    chk("rst_mid.in_eval", 32'(lut_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid.outputs", {27'h0, in_ready, out_valid, lut_req, busy, |out_data}, 32'h10);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    chk("rst_mid.no_out_valid", 32'(seen), 32'd0);
    start_vec("rst_after", 16'h0001, 1'b0, 0, 0, 0, 1'b0, base);
    finish_vec("rst_after", 16'h2525, 0, 1, base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/logicnets_layer_sched.md
LOGICNETS_LAYER_SCHED -- requirements
Module: logicnets_layer_sched

Interface
REQ-001 SHALL have parameter IN_BITS, default 16, width of the layer input vector.
REQ-002 SHALL have parameter NEURONS, default 16, number of neurons evaluated serially on one shared LUT.
REQ-003 SHALL have parameter FANIN, default 6, inputs per neuron LUT; IW=clog2(IN_BITS), NW=clog2(NEURONS).
REQ-004 SHALL use one clock `clk`; reset `rst` is asynchronous and active-high.
REQ-005 Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- in_valid  in  1  input vector valid
- in_ready  out  1  input vector accepted when in_valid&in_ready
- in_data  in  IN_BITS  layer input vector
- out_valid  out  1  result vector valid
- out_ready  in  1  result consumed when out_valid&out_ready
- out_data  out  NEURONS  one bit per neuron; bit n = neuron n
- lut_req  out  1  shared-LUT lookup strobe
- lut_sel  out  NW  neuron index addressed
- lut_in  out  FANIN  gathered LUT address; bit s = slot s
- lut_out  in  1  LUT result, valid exactly 1 cycle after lut_req
- cfg_we  in  1  connectivity-table write strobe
- cfg_neuron  in  NW  neuron written
- cfg_slot  in  clog2(FANIN)  slot written
- cfg_idx  in  IW  input-bit index stored
- busy  out  1  high in any state except IDLE

Function
REQ-006 SHALL hold a connectivity table idx[n][s] (NEURONS x FANIN x IW bits); lut_in[s] = x[idx[lut_sel][s]], x = latched input.
REQ-007 FSM states: IDLE, EVAL, DRAIN, HOLD; in_ready=1 only in IDLE.
REQ-008 IDLE: on in_valid&in_ready latch in_data to x, clear result, neuron counter n=0, go EVAL.
REQ-009 EVAL: each cycle assert lut_req with lut_sel=n, increment n; after issuing n=NEURONS-1 go DRAIN.
REQ-010 lut_out sampled the cycle after each lut_req and written to result bit of the neuron issued one cycle earlier.
REQ-011 DRAIN: capture final lut_out, lut_req=0, go HOLD.
REQ-012 HOLD: out_valid=1, out_data=result, both stable until out_valid&out_ready, then go IDLE.
REQ-013 Latency: acceptance at edge T0 -> out_valid high from cycle T0+NEURONS+2; minimum spacing between accepted vectors NEURONS+3 cycles.
REQ-014 lut_req SHALL be 0 outside EVAL; lut_sel/lut_in are don't-care when lut_req=0 but SHALL be driven without X.
REQ-015 cfg_we honoured only in IDLE; cfg_we in any other state ignored (table unchanged).
REQ-016 cfg_we coincident with input acceptance in IDLE: write takes effect and the new vector uses the updated table.
REQ-017 cfg_slot >= FANIN or cfg_neuron >= NEURONS: write ignored.
REQ-018 in_valid deasserting while in_ready=0 has no effect; no input is lost or duplicated.

Reset
REQ-019 On rst: state IDLE, in_ready=1, out_valid=0, out_data=0, lut_req=0, busy=0, n=0, x=0.
REQ-020 On rst: idx[n][s] = (n*FANIN+s) mod IN_BITS.
REQ-021 rst mid-evaluation SHALL abort the vector; no out_valid for it after release.

Structure
REQ-022 Shared package holds FSM state enum, default-mapping function, and parameter defaults.
REQ-023 Connectivity table plus FANIN-way input gather SHALL be one sub-module, logicnets_fanin_gather.

Verification (bench LUT model: lut_out = XOR of lut_in, 1-cycle latency; default parameters)
REQ-024 After reset, in_data=16'h0001 -> out_data=16'h2525, out_valid first high 18 cycles after acceptance.
REQ-025 After reset, in_data=16'h8000 -> out_data=16'hA4A4.
REQ-026 Write neuron 3 slot 0 = 15 in IDLE, then in_data=16'h8000 -> out_data=16'hA4AC.
REQ-027 out_ready low 5 cycles in HOLD -> out_data stable, in_ready=0, lut_req=0 throughout; accepted on first out_ready cycle, IDLE next.
REQ-028 cfg_we during EVAL (neuron 0 slot 0 = 15) -> ignored; next in_data=16'h0001 still yields 16'h2525.
REQ-029 rst pulsed at 5th EVAL cycle -> all outputs at reset values, table back to default, no out_valid; next in_data=16'h0001 yields 16'h2525.
